// File: rtl/fp_left_normalizer.sv
// fp_left_normalizer: multi-cycle leading-zero left normalizer for 48-bit mantissas with denormal floor.
// Optional out_sticky port (OR of final m[23:0]) enabled by defining LSHIFT_STICKY_EN.
module fp_left_normalizer (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [47:0] in_mant,
  input  logic [7:0]  in_exp,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [22:0] out_frac,
  output logic [7:0]  out_exp,
`ifdef LSHIFT_STICKY_EN
  output logic        out_sticky,
`endif
  output logic [5:0]  out_shift
);
  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;
  state_t state, state_n;
  logic [47:0] m, m_n;
  logic [7:0] e, e_n;
  logic [5:0] cnt, cnt_n;
  logic load;
  assign in_ready = state == IDLE;
  // when load is set, the *_n values are exactly the final result to publish
  always_comb begin
    state_n = state;
    m_n = m;
    e_n = e;
    cnt_n = cnt;
    load = 1'b0;
    case (state)
      IDLE: if (in_valid) begin
        m_n = in_mant;
        e_n = in_exp;
        cnt_n = 6'd0;
        load = in_mant == 48'd0 || in_exp == 8'd0;
        state_n = load ? DONE : SHIFT;
      end
      SHIFT: if (m[47] || e <= 8'd1) begin
        state_n = DONE;
        load = 1'b1;
      end else if (m[47:40] == 8'd0 && e > 8'd8) begin
        m_n = m << 8;
        e_n = e - 8'd8;
        cnt_n = cnt + 6'd8;
      end else begin
        m_n = m << 1;
        e_n = e - 8'd1;
        cnt_n = cnt + 6'd1;
      end
      DONE: state_n = out_ready ? IDLE : DONE;
      default: state_n = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      m <= '0;
      e <= '0;
      cnt <= '0;
      out_valid <= 1'b0;
      out_frac <= '0;
      out_exp <= '0;
      out_shift <= '0;
`ifdef LSHIFT_STICKY_EN
      out_sticky <= 1'b0;
`endif
    end else begin
      state <= state_n;
      m <= m_n;
      e <= e_n;
      cnt <= cnt_n;
      out_valid <= state_n == DONE;
      if (load) begin
        out_frac <= m_n[46:24];
        out_exp <= m_n[47] ? e_n : 8'd0;
        out_shift <= cnt_n;
`ifdef LSHIFT_STICKY_EN
        out_sticky <= |m_n[23:0];
`endif
      end
    end
  end
endmodule

// File: tb/tb_fp_left_normalizer.sv
// tb_fp_left_normalizer: directed vectors with a scoreboard queue checked by an independent output monitor.
module tb_fp_left_normalizer;
  logic clk = 1'b0;
  logic rst, in_valid, in_ready, out_valid, out_ready;
  logic [47:0] in_mant;
  logic [7:0] in_exp, out_exp;
  logic [22:0] out_frac;
  logic [5:0] out_shift;
`ifdef LSHIFT_STICKY_EN
  logic out_sticky;
`endif
  typedef struct {logic [22:0] f; logic [7:0] x; logic [5:0] s; logic k;} exp_t;
  exp_t q[$];
  int checks = 0;
  int errors = 0;

  fp_left_normalizer dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_mant(in_mant), .in_exp(in_exp), .out_valid(out_valid), .out_ready(out_ready),
    .out_frac(out_frac), .out_exp(out_exp),
`ifdef LSHIFT_STICKY_EN
    .out_sticky(out_sticky),
`endif
    .out_shift(out_shift)
  );

  always #5 clk = ~clk;

  task automatic chk(input string n, input logic [63:0] a, input logic [63:0] b);
    checks++;
    if (a !== b) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", n, a, b);
    end
  endtask

  // monitor: one pop per consumed result, sampled mid-cycle
  always @(negedge clk) begin
    if (!rst && out_valid && out_ready) begin
      if (q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_result actual=%0h required=none", out_frac);
      end else begin
        exp_t x;
        x = q.pop_front();
        chk("frac", out_frac, x.f);
        chk("exp", out_exp, x.x);
        chk("shift", out_shift, x.s);
`ifdef LSHIFT_STICKY_EN
        chk("sticky", out_sticky, x.k);
`endif
      end
    end
  end

  task automatic send(input logic [47:0] mt, input logic [7:0] ex, input logic [22:0] f,
                      input logic [7:0] x, input logic [5:0] s, input logic k,
                      input int lat, input bit hold);
    int n;
    n = 0;
    while (!in_ready && n < 50) begin @(posedge clk); #1; n++; end
    chk("ready_before_send", in_ready, 1);
    in_mant = mt;
    in_exp = ex;
    in_valid = 1'b1;
    out_ready = !hold;
    q.push_back('{f, x, s, k});
    @(posedge clk); #1;
    in_valid = 1'b0;
    n = 1;
    while (!out_valid && n < 40) begin @(posedge clk); #1; n++; end
    chk("latency", n, lat);
    if (hold) begin
      for (int i = 0; i < 5; i++) begin
        chk("hold_valid", out_valid, 1);
        chk("hold_in_ready", in_ready, 0);
        chk("hold_frac", out_frac, f);
        chk("hold_exp", out_exp, x);
        chk("hold_shift", out_shift, s);
        in_valid = i == 2;
        in_mant = 48'h1;
        in_exp = 8'd3;
        @(posedge clk); #1;
      end
      in_valid = 1'b0;
      out_ready = 1'b1;
    end
    @(posedge clk); #1;
    chk("consumed_valid", out_valid, 0);
    chk("consumed_in_ready", in_ready, 1);
  endtask

  task automatic chk_idle_zero(input string n);
    chk({n, "_valid"}, out_valid, 0);
    chk({n, "_in_ready"}, in_ready, 1);
    chk({n, "_outs"}, {out_frac, out_exp, out_shift}, 0);
`ifdef LSHIFT_STICKY_EN
    chk({n, "_sticky"}, out_sticky, 0);
`endif
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1);
  end

  initial begin
    rst = 1'b1;
    in_valid = 1'b0;
    out_ready = 1'b1;
    in_mant = '0;
    in_exp = '0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    chk_idle_zero("reset");
    send(48'h800000000001, 8'd100, 23'h0, 8'd100, 6'd0, 1'b1, 2, 1'b0);
    send(48'h000001000000, 8'd127, 23'h0, 8'd104, 6'd23, 1'b0, 11, 1'b0);
    send(48'h000000000001, 8'd5, 23'h0, 8'd0, 6'd4, 1'b1, 6, 1'b0);
    send(48'h000000000000, 8'd50, 23'h0, 8'd0, 6'd0, 1'b0, 1, 1'b0);
    send(48'h000000000001, 8'd200, 23'h0, 8'd153, 6'd47, 1'b0, 14, 1'b0);
    send(48'h123456789ABC, 8'd0, 23'h123456, 8'd0, 6'd0, 1'b1, 1, 1'b0);
    send(48'h800000000000, 8'd0, 23'h0, 8'd0, 6'd0, 1'b0, 1, 1'b0);
    send(48'h000000000100, 8'd1, 23'h0, 8'd0, 6'd0, 1'b1, 2, 1'b0);
    send(48'h000000000001, 8'd9, 23'h0, 8'd0, 6'd8, 1'b1, 3, 1'b0);
    send(48'h000000000001, 8'd8, 23'h0, 8'd0, 6'd7, 1'b1, 9, 1'b0);
    send(48'h00F000000000, 8'd100, 23'h700000, 8'd92, 6'd8, 1'b0, 3, 1'b0);
    send(48'h400000000000, 8'd10, 23'h0, 8'd9, 6'd1, 1'b0, 3, 1'b0);
    send(48'h000055555555, 8'd127, 23'h2AAAAA, 8'd110, 6'd17, 1'b1, 5, 1'b1);
    // abort an operation mid-SHIFT; nothing may come out for it
    in_mant = 48'h000000000001;
    in_exp = 8'd200;
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (3) begin @(posedge clk); #1; end
    chk("mid_shift_busy", in_ready, 0);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    chk_idle_zero("abort");
    repeat (15) begin @(posedge clk); #1; end
    chk("abort_no_result", out_valid, 0);
    send(48'h000001000000, 8'd127, 23'h0, 8'd104, 6'd23, 1'b0, 11, 1'b0);
    repeat (3) @(posedge clk);
    #1 chk("queue_empty", q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/fp_left_normalizer.md
# fp_left_normalizer

Multi-cycle leading-zero normalizer for the FP datapath; the left-shift counterpart of the product right shifter. It accepts a 48-bit unnormalized mantissa and an 8-bit biased exponent. It shifts left until the hidden bit reaches bit 47, or until the exponent hits the denormal floor, and returns a 23-bit fraction, the adjusted exponent and the shift count. It sits after the adder/subtractor mantissa stage, where cancellation leaves leading zeros.

## Interface
Parameters:
- none; widths are fixed by single-precision format.

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  reset; synchronous, active-high, single clock domain
- in_valid  in  1  input operand valid
- in_ready  out  1  block can accept; high only in IDLE
- in_mant  in  48  unnormalized mantissa, hidden-bit position is bit 47
- in_exp  in  8  biased exponent of in_mant
- out_valid  out  1  result valid; held until consumed
- out_ready  in  1  downstream accepts result
- out_frac  out  23  normalized mantissa bits [46:24], truncated
- out_exp  out  8  adjusted exponent; 0 if result is denormal or zero
- out_shift  out  6  total left shift applied, 0..47

## Operation
- States: IDLE, SHIFT, DONE.
- IDLE: in_ready=1. When in_valid is high, latch in_mant and in_exp, clear the count, then:
  - if in_mant==0 or in_exp==0: go to DONE with no shift;
  - else go to SHIFT.
- SHIFT: one decision per cycle, using the registered mantissa m and exponent e:
  - if m[47]==1 or e<=1: go to DONE;
  - else if m[47:40]==0 and e>8: m<<=8, e-=8, count+=8;
  - else: m<<=1, e-=1, count+=1.
- e never drops below 1 inside SHIFT. Zeros shift in at the LSB.
- DONE outputs:
  - out_valid=1; out_frac=m[46:24]; out_shift=count;
  - out_exp=e if m[47]==1, else 0 (denormal or zero).
  - Go to IDLE when out_ready is high.
- Outputs are registered and stay stable while out_valid=1 and out_ready=0.
- Only one operand is in flight at a time. in_valid is ignored outside IDLE.

## Timing
- Reset, one rising edge with rst=1:
  - state=IDLE, in_ready=1, out_valid=0;
  - out_frac=0, out_exp=0, out_shift=0; internal m, e and count cleared.
- rst takes priority over every transition. Asserting it in SHIFT or DONE aborts the operation and discards the result. in_ready=1 on the cycle after rst deasserts.
- Accept at edge N:
  - zero or in_exp==0 operand: out_valid=1 from N+1;
  - otherwise: out_valid=1 from N+1+S+1, where S is the number of shifting cycles.
- Already-normalized operand: out_valid at N+2.
- Worst case (bit 0 set, large exponent): 5 coarse steps + 7 single steps, out_valid at N+14.
- Consume edge (out_valid and out_ready both high): out_valid falls and in_ready rises on the next cycle. There is no same-cycle accept while in DONE.

## Configuration
- LSHIFT_STICKY_EN defined:
  - adds port out_sticky (out, 1), equal to the OR of final m[23:0];
  - it is registered in DONE, reset to 0, and held under backpressure.
- LSHIFT_STICKY_EN undefined: the port and its logic are absent. All other behaviour is identical.

## Test plan
- in_mant=48'h800000000001, in_exp=100 → out_frac=0, out_exp=100, out_shift=0, out_valid 2 cycles after accept; with LSHIFT_STICKY_EN, out_sticky=1.
- in_mant=48'h000001000000, in_exp=127 → shifts 8,8 then 1×7; out_frac=0, out_exp=104, out_shift=23, out_valid at accept+11.
- in_mant=48'h000000000001, in_exp=5 → 4 single shifts, floor reached; out_frac=0, out_exp=0, out_shift=4.
- in_mant=0, in_exp=50 → out_frac=0, out_exp=0, out_shift=0, out_valid at accept+1.
- Backpressure: hold out_ready=0 for 5 cycles in DONE → outputs stable, in_ready=0, a second in_valid pulse is ignored; result consumed on the first out_ready=1.
- Assert rst for 1 cycle mid-SHIFT → next cycle IDLE, out_valid=0, in_ready=1, all outputs 0; a new operand then completes correctly.
